// File: rtl/mux_sel_ctrl_pkg.sv
// ============================================================================
// Module : mux_sel_ctrl_pkg
// Brief  : Shared FSM encoding, default constants and width helper for mux_sel_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_sel_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } db_state_t;

  localparam int unsigned c_DB_CYCLES_DEF   = 16;
  localparam int unsigned c_SETTLE_DEF      = 4;
  localparam int unsigned c_CNT_W_DEF       = 8;
  localparam int unsigned c_AUTO_PERIOD_DEF = 64;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_sel_ctrl_if.sv
// ============================================================================
// Module : mux_sel_ctrl_if
// Brief  : Button input and select/status outputs of mux_sel_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mux_sel_ctrl_if #(
  parameter int unsigned CNT_W = mux_sel_ctrl_pkg::c_CNT_W_DEF
) ();

  logic             btn_in;
  logic             sel;
  logic             sel_valid;
  logic [CNT_W-1:0] toggle_cnt;

  modport master (
    output btn_in,
    input  sel,
    input  sel_valid,
    input  toggle_cnt
  );

  modport slave (
    input  btn_in,
    output sel,
    output sel_valid,
    output toggle_cnt
  );

endinterface

`default_nettype wire

// File: rtl/mux_sel_ctrl_btn_sync.sv
// ============================================================================
// Module : mux_sel_ctrl_btn_sync
// Brief  : Two-flop synchronizer for an asynchronous single-bit input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_sel_ctrl_btn_sync (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/mux_sel_ctrl.sv
// ============================================================================
// Module : mux_sel_ctrl
// Brief  : Debounced pushbutton -> toggling mux select with settle flag and
//          toggle counter. Define MUX_SEL_AUTO_TOGGLE_EN for periodic auto toggles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_sel_ctrl
  import mux_sel_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = c_DB_CYCLES_DEF,
  parameter int unsigned SETTLE      = c_SETTLE_DEF,
  parameter int unsigned CNT_W       = c_CNT_W_DEF
`ifdef MUX_SEL_AUTO_TOGGLE_EN
  ,
  parameter int unsigned AUTO_PERIOD = c_AUTO_PERIOD_DEF
`endif
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mux_sel_ctrl_if.slave bus
);

  localparam int unsigned          c_DBC_W    = cnt_w(DB_CYCLES);
  localparam int unsigned          c_STL_W    = cnt_w(SETTLE);
  localparam logic [c_DBC_W-1:0]   c_DBC_LAST = c_DBC_W'(DB_CYCLES - 1);
  localparam logic [c_STL_W-1:0]   c_STL_LAST = c_STL_W'(SETTLE - 1);

  logic               w_btn_s;
  db_state_t          r_state;
  db_state_t          w_state_nxt;
  logic [c_DBC_W-1:0] r_dbc;
  logic [c_DBC_W-1:0] w_dbc_nxt;
  logic               w_btn_tog;
  logic               w_auto_tog;
  logic               w_toggle;
  logic               r_sel;
  logic               r_sel_valid;
  logic [CNT_W-1:0]   r_toggle_cnt;
  logic [c_STL_W-1:0] r_settle;

  mux_sel_ctrl_btn_sync u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_in),
    .q   (w_btn_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dbc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dbc   <= w_dbc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dbc_nxt   = r_dbc;
    w_btn_tog   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = ST_DEBOUNCE;
          w_dbc_nxt   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!w_btn_s) begin
          w_state_nxt = ST_IDLE;
        end else if (r_dbc == c_DBC_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_btn_tog   = 1'b1;
        end else begin
          w_dbc_nxt = r_dbc + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt = ST_RELEASE;
          w_dbc_nxt   = '0;
        end
      end
      ST_RELEASE: begin
        // A high during release is bounce of the same press, so no new toggle.
        if (w_btn_s) begin
          w_state_nxt = ST_PRESSED;
        end else if (r_dbc == c_DBC_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_dbc_nxt = r_dbc + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef MUX_SEL_AUTO_TOGGLE_EN
  localparam int unsigned        c_PER_W    = cnt_w(AUTO_PERIOD);
  localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(AUTO_PERIOD - 1);

  logic [c_PER_W-1:0] r_period;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= '0;
    end else if (r_period == c_PER_LAST) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + 1'b1;
    end
  end

  assign w_auto_tog = (r_period == c_PER_LAST);
`else
  assign w_auto_tog = 1'b0;
`endif

  // OR-merge so coincident sources flip sel once.
  assign w_toggle = w_btn_tog | w_auto_tog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel        <= 1'b0;
      r_sel_valid  <= 1'b0;
      r_toggle_cnt <= '0;
      r_settle     <= '0;
    end else if (w_toggle) begin
      r_sel        <= ~r_sel;
      r_toggle_cnt <= r_toggle_cnt + 1'b1;
      r_sel_valid  <= 1'b0;
      r_settle     <= '0;
    end else if (!r_sel_valid) begin
      if (r_settle == c_STL_LAST) begin
        r_sel_valid <= 1'b1;
      end else begin
        r_settle <= r_settle + 1'b1;
      end
    end
  end

  assign bus.sel        = r_sel;
  assign bus.sel_valid  = r_sel_valid;
  assign bus.toggle_cnt = r_toggle_cnt;

endmodule

`default_nettype wire
